// File: rtl/tbuf_frame_sched.sv
// Purpose: frame-granular round-robin arbiter feeding the transpose buffer's single write port.
// Latency: request to grant 1 cycle; accepted word appears on buf_valid/buf_data 1 cycle later.
// Backpressure: only the owner sees req_ready, and only while streaming; held off until buf_done.
// Optional build macro TBUF_SCHED_TIMEOUT_EN adds a WAIT_DONE watchdog that sets the sticky err.
module tbuf_frame_sched #(
  parameter int N_REQ     = 4,
  parameter int DW        = 32,
  parameter int FRAME_LEN = 884,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    grant,
  output logic                buf_valid,
  output logic [DW-1:0]       buf_data,
  input  logic                buf_done,
  output logic                busy,
  output logic                err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0]    LAST_CNT = CW'(FRAME_LEN - 1);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic [IW-1:0] next_ptr;
  logic [CW-1:0] word_cnt;
  logic          accept;
  logic [DW-1:0] gnt_word;

`ifdef TBUF_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wait_cnt;
`else
  // No watchdog in this build; keep the parameter referenced so it stays lint-quiet.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign err = 1'b0;
`endif

  // Ready only goes to the owner, and only while the frame is being collected.
  assign req_ready = (state == S_STREAM) ? grant : '0;
  assign accept    = (state == S_STREAM) && ((req_valid & grant) != '0);
  assign gnt_word  = req_data[gnt_idx*DW +: DW];
  assign next_ptr  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
  assign busy      = (state != S_IDLE);

  // Round-robin search: first requesting index at or after rr_ptr, wrapping.
  always_comb begin : pick_c
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  // Scheduler FSM with registered grant and word output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      gnt_idx   <= '0;
      rr_ptr    <= '0;
      word_cnt  <= '0;
      buf_valid <= 1'b0;
      buf_data  <= '0;
`ifdef TBUF_SCHED_TIMEOUT_EN
      wait_cnt  <= '0;
      err       <= 1'b0;
`endif
    end else begin
      buf_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant    <= ONE_HOT0 << pick_idx;
            gnt_idx  <= pick_idx;
            word_cnt <= '0;
            state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept) begin
            buf_valid <= 1'b1;
            buf_data  <= gnt_word;
            if (word_cnt == LAST_CNT) begin
              state <= S_WAIT;
`ifdef TBUF_SCHED_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (buf_done) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
`ifdef TBUF_SCHED_TIMEOUT_EN
          end else if (wait_cnt == TO_LAST) begin
            // Buffer never acknowledged the frame: flag it and move on.
            err    <= 1'b1;
            grant  <= '0;
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tbuf_frame_sched.md
# tbuf_frame_sched

Frame-granular round-robin scheduler that shares the single 32-bit write port of the 884-word transpose collection buffer among `N_REQ` upstream word streams. It grants one requester for exactly `FRAME_LEN` words, forwards those words as a registered valid/data stream, then holds off all requesters until the buffer's one-cycle frame-complete pulse returns. It sits between the layer's feature-map producers and the transpose buffer.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DW`, 32: word width.
- `FRAME_LEN`, 884: words per frame; must equal buffer depth.
- `TIMEOUT`, 64: cycles allowed in WAIT_DONE (only with `TBUF_SCHED_TIMEOUT_EN`).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: level request per requester; held until its grant ends.
- `req_valid` in N_REQ: word valid per requester.
- `req_data` in N_REQ*DW: packed words; requester k at bits [k*DW +: DW].
- `req_ready` out N_REQ: word accepted when `req_valid[k] & req_ready[k]`.
- `grant` out N_REQ: one-hot owner of the current frame, all-zero when idle.
- `buf_valid` out 1: registered word strobe to buffer `valid_in`.
- `buf_data` out DW: registered word to buffer `data_in`.
- `buf_done` in 1: buffer `valid_out` pulse, one cycle per completed frame.
- `busy` out 1: high in any state except IDLE.
- `err` out 1: sticky timeout flag; cleared only by reset.

## Operation
- States: IDLE, STREAM, WAIT_DONE.
- IDLE: if any `req` bit high, pick first set bit at or after `rr_ptr` (wrapping), register `grant`, clear `word_cnt`, go STREAM. No request: stay.
- STREAM: `req_ready = grant` (combinational from registered grant and state). Each accepted word: `buf_valid<=1`, `buf_data<=` granted word, `word_cnt++`. No accept: `buf_valid<=0`, `buf_data` holds. Accept with `word_cnt==FRAME_LEN-1`: go WAIT_DONE, `req_ready` low from next cycle.
- WAIT_DONE: `req_ready`=0, `buf_valid`=0, `grant` held. On `buf_done`: clear `grant`, `rr_ptr <=` granted index+1 mod N_REQ, go IDLE.
- `word_cnt` width `$clog2(FRAME_LEN)`; never exceeds FRAME_LEN-1.
- Owner dropping `req` mid-frame is ignored; frame still needs FRAME_LEN words.
- `buf_done` outside WAIT_DONE is ignored.
- Non-granted `req_valid` ignored; their `req_ready` stays 0.

## Timing
- Reset values: `grant`=0, `req_ready`=0, `buf_valid`=0, `buf_data`=0, `busy`=0, `err`=0, `rr_ptr`=0, state IDLE, `word_cnt`=0.
- Request to grant: `req` high at edge n in IDLE -> `grant`/`busy` high after edge n; `req_ready` high same cycle.
- Word latency: accept at edge m -> `buf_valid`/`buf_data` valid for the cycle after edge m.
- Full throughput: one word per cycle; 884-word frame occupies 884 consecutive STREAM cycles minimum.
- Last accept at edge m -> WAIT_DONE after m; `buf_done` at edge d -> IDLE and `grant`=0 after d; next grant earliest after d+1.
- Reset asserted mid-frame: all outputs return to reset values immediately; partial frame discarded.

## Configuration
- `TBUF_SCHED_TIMEOUT_EN` defined: WAIT_DONE counter counts cycles; reaching TIMEOUT without `buf_done` sets `err`, clears `grant`, advances `rr_ptr`, returns IDLE. Counter clears on WAIT_DONE entry.
- Undefined: no counter; WAIT_DONE waits indefinitely; `err` tied 0.

## Test plan
- Reset: drive random inputs with `rst_n`=0 -> all outputs 0; release, `req`=0 -> stays IDLE, `busy`=0.
- Single frame: `req`=4'b0100, `req_valid[2]` always high, data=index 0..883 -> `grant`=4'b0100, 884 `buf_valid` pulses with data 0..883, `req_ready` low after last; `buf_done` pulse -> `grant`=0.
- Round robin: `req`=4'b1111 held, `buf_done` 2 cycles after each frame -> grants 0,1,2,3,0 in order, each exactly 884 words.
- Backpressure: owner `req_valid` toggles every other cycle -> still exactly 884 words, `buf_valid` matches accepts one cycle later, no gaps dropped.
- Stray/other inputs: `buf_done` during STREAM and `req_valid` on non-owner -> no state change, no extra words.
- Timeout (macro on, TIMEOUT=64): no `buf_done` after frame -> `err`=1 64 cycles after WAIT_DONE entry, IDLE, next requester granted; macro off -> stays WAIT_DONE, `err`=0.
